// File: rtl/cmplx_sym_upsampler.sv
// cmplx_sym_upsampler: QPSK symbol mapper emitting sps complex samples per symbol
module cmplx_sym_upsampler #(
    parameter int          sps  = 4,
    parameter logic [15:0] amp  = 16'h4000,
    parameter bit          hold = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sym_i,
    input  logic        sym_valid_i,
    output logic        sym_ready_o,
    output logic [15:0] y_a_o,
    output logic [15:0] y_b_o,
    output logic        y_valid_o,
    input  logic        y_ready_i,
    output logic        underrun_o
);
    localparam int pw = sps > 1 ? $clog2(sps) : 1;
    localparam logic [pw-1:0] last = pw'(sps - 1);
    localparam logic [15:0] neg = ~amp + 16'd1;
    logic [pw-1:0] phase;
    logic [15:0]   s_a, s_b, m_a, m_b;
    logic          at_last, sym_acc, y_xfer;
    assign at_last     = phase == last;
    assign sym_ready_o = !y_valid_o | (y_ready_i & at_last);
    assign sym_acc     = sym_valid_i & sym_ready_o;
    assign y_xfer      = y_valid_o & y_ready_i;
    assign m_a         = sym_i[0] ? neg : amp;
    assign m_b         = sym_i[1] ? neg : amp;
    // output register, symbol register and phase counter advance on transfers
    always_ff @(posedge clk) begin
        if (rst) begin
            y_a_o      <= '0;
            y_b_o      <= '0;
            y_valid_o  <= 1'b0;
            underrun_o <= 1'b0;
            phase      <= '0;
            s_a        <= '0;
            s_b        <= '0;
        end else begin
            underrun_o <= 1'b0;
            if (sym_acc) begin
                y_a_o     <= m_a;
                y_b_o     <= m_b;
                s_a       <= m_a;
                s_b       <= m_b;
                y_valid_o <= 1'b1;
                phase     <= '0;
            end else if (y_xfer) begin
                if (at_last) begin
                    y_a_o      <= '0;
                    y_b_o      <= '0;
                    y_valid_o  <= 1'b0;
                    phase      <= '0;
                    underrun_o <= 1'b1;
                end else begin
                    y_a_o <= hold ? s_a : '0;
                    y_b_o <= hold ? s_b : '0;
                    phase <= phase + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cmplx_sym_upsampler.sv
// tb_cmplx_sym_upsampler: randomized check of three configurations against a sample-count model
module tb_cmplx_sym_upsampler;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sym [3];
    logic        sv [3], yr [3], sr [3], yv [3], ur [3];
    logic [15:0] ya [3], yb [3];
    int          nvec = 0, nbad = 0;
    int          rem [3];
    logic [31:0] cur [3];
    logic        uexp [3];
    int          spsv [3] = '{4, 1, 4};
    bit          holdv [3] = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        cmplx_sym_upsampler #(.sps(g == 1 ? 1 : 4), .hold(g == 2)) dut (
            .clk(clk), .rst(rst), .sym_i(sym[g]), .sym_valid_i(sv[g]), .sym_ready_o(sr[g]),
            .y_a_o(ya[g]), .y_b_o(yb[g]), .y_valid_o(yv[g]), .y_ready_i(yr[g]), .underrun_o(ur[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] qmap(input logic [1:0] s);
        return {s[0] ? 16'hC000 : 16'h4000, s[1] ? 16'hC000 : 16'h4000};
    endfunction

    initial begin
        logic rst_prev;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sym[i] = 2'b00; sv[i] = 1'b0; yr[i] = 1'b1;
            rem[i] = 0; cur[i] = '0; uexp[i] = 1'b0;
        end
        rst_prev = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_prev = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            int mode;
            mode = (c / 150) % 3;
            rst = (mode == 0) && ($urandom_range(0, 60) == 0);
            for (int i = 0; i < 3; i++) begin
                sym[i] = 2'($urandom);
                sv[i]  = mode == 1 ? 1'b1 : ($urandom_range(0, 9) < 7);
                yr[i]  = mode == 1 ? 1'b1 : (mode == 2 ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 7));
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                logic rdy, acc, xfer;
                logic [31:0] smp;
                rdy = (rem[i] == 0) || (rem[i] == 1 && yr[i]);
                chk($sformatf("ready%0d", i), {31'b0, sr[i]}, {31'b0, rdy});
                chk($sformatf("valid%0d", i), {31'b0, yv[i]}, {31'b0, rem[i] > 0});
                chk($sformatf("underrun%0d", i), {31'b0, ur[i]}, {31'b0, uexp[i]});
                smp = (rem[i] == spsv[i] || holdv[i]) ? cur[i] : 32'h0;
                if (rem[i] > 0) chk($sformatf("sample%0d", i), {ya[i], yb[i]}, smp);
                if (rst_prev) chk($sformatf("rstdata%0d", i), {ya[i], yb[i]}, 32'h0);
                acc  = sv[i] && rdy;
                xfer = rem[i] > 0 && yr[i];
                if (rst) begin
                    rem[i] = 0; uexp[i] = 1'b0;
                end else begin
                    uexp[i] = xfer && rem[i] == 1 && !acc;
                    if (xfer) rem[i]--;
                    if (acc) begin
                        rem[i] = spsv[i];
                        cur[i] = qmap(sym[i]);
                    end
                end
            end
            rst_prev = rst;
            @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
